hb_interp2_mc: RTL and testbench
================================

Name: hb_interp2_mc

Overview:
- Parametrised 2x halfband interpolator for N_CH parallel complex/real lanes, running on the single system clock.
- Replaces the divided-clock approach with valid/ready handshakes.
- Each accepted input vector produces two output vectors: even phase, then odd phase.
- Adds a per-sample sample-and-hold bypass mode and backpressure support.

Parameters:
- DATA_W, 16, width of each lane sample (signed two's complement).
- COEF_W, 16, coefficient width; format Q1.(COEF_W-1).
- N_CH, 2, number of parallel lanes, packed LSB-first in the data buses.
- K, 2, half-length; total taps N_TAPS = 4K-1. The even-branch coefficients g[0..K-1] come from the package.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- io_in_valid, in, 1, input sample vector valid.
- io_in_ready, out, 1, block can accept an input vector.
- io_in_data, in, N_CH*DATA_W, lane c occupies bits [c*DATA_W +: DATA_W].
- io_bypass, in, 1, sampled with the input; selects sample-and-hold instead of filtering.
- io_out_valid, out, 1, output vector valid.
- io_out_ready, in, 1, downstream accepts the output vector.
- io_out_data, out, N_CH*DATA_W, output vector with the same packing.

Behaviour:
- Clocking and reset: single clock. reset is synchronous and active-high.
- Reset values: io_out_valid=0, io_out_data=0, all delay-line taps=0, state=EMPTY. io_in_ready=0 while reset is high.
- Accept occurs when io_in_valid && io_in_ready. Transfer occurs when io_out_valid && io_out_ready.
- Per lane, on accept:
  - The delay line shifts: d[0]<=x[n], d[j]<=d[j-1], for a depth of 2K.
  - Both phase results are computed from the new sample plus the old taps and registered into ev_reg/od_reg in the same edge.
- Even phase: y[2n] = sum over j=0..K-1 of g[j]*(x[n-j] + x[n-2K+1+j]).
- Odd phase: y[2n+1] = x[n-K+1]. The centre tap has gain 1 after the x2 interpolation gain, so no multiplier is used.
- Arithmetic:
  - Symmetric pre-add is DATA_W+1 bits.
  - Accumulator is DATA_W+COEF_W+clog2(K)+1 bits.
  - Round half-up by adding 2^(COEF_W-2), then arithmetic shift right by COEF_W-1.
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Bypass (io_bypass=1 at accept): ev_reg=od_reg=x[n]. The delay line still updates, so a later return to filtering is glitch-consistent.
- FSM states: EMPTY, PH0 (presenting ev_reg), PH1 (presenting od_reg).
  - EMPTY: accept -> PH0.
  - PH0: transfer -> PH1.
  - PH1: transfer with accept -> PH0 (new results loaded); transfer without accept -> EMPTY.
- io_in_ready = (state==EMPTY) || (state==PH1 && io_out_ready). This is combinational on io_out_ready; there is no combinational path from io_in_valid to io_out_*.
- io_out_valid = (state!=EMPTY).
- io_out_data is held stable while io_out_valid && !io_out_ready.
- Latency: first output vector one cycle after accept.
- Peak throughput: one input per 2 cycles, one output per cycle. Sustained valid/ready high gives a gap-free output stream.
- Reset mid-operation: any pending phase is discarded, the delay line is cleared, and the block returns to EMPTY on the next edge. Post-reset responses are identical to a fresh start.
- All lanes share the state, handshake and coefficients; they differ only in data.

Decomposition:
- Package hb_interp_pkg holds:
  - the coefficient constant array G for the default K=2: g[0]=-2048, g[1]=18432 (from h = [-1,0,9,16,9,0,-1]/32);
  - the rounding constant;
  - the accumulator-width function;
  - the FSM state enum.
- One sub-module, hb_lane: delay line, pre-add/MAC, round/saturate and bypass mux for one lane. It is instantiated N_CH times by a generate loop.
- The top level holds the FSM and the handshake.

Test Plan:
- Impulse, lane 0: inputs 16384, 0, 0, 0, bypass=0, ready always high -> output stream -1024, 0, 9216, 16384, 9216, 0, -1024, 0.
- DC: constant 10000 on both lanes -> after 4 inputs every output equals 10000. After the first valid output, io_out_valid stays high continuously and io_in_ready toggles 1,0,1,0.
- Saturation: inputs -32768, 32767, 32767, -32768 -> the even output for n=3 (unsaturated 40959) equals 32767. The odd output for n=3 equals 32767.
- Backpressure: hold io_out_ready=0 for 3 cycles while in PH0 -> io_out_data unchanged, io_in_ready=0, no input lost. Outputs resume in the same order once ready returns.
- Bypass and lanes: lane 0=1234, lane 1=-5 with bypass=1 -> two consecutive outputs of {1234,-5}. Then bypass=0 with the impulse on lane 1 only -> lane 1 reproduces the impulse response and lane 0 shows the filtered tail of 1234.
- Reset mid-PH1: assert reset for 1 cycle -> next cycle io_out_valid=0 and io_out_data=0. A repeated impulse then yields exactly the impulse-response sequence above.

Source files
------------

// File: rtl/hb_interp_pkg.sv
// Shared constants, helpers and FSM encoding for the 2x halfband interpolator.
package hb_interp_pkg;

  localparam int unsigned G_W   = 16;
  localparam int unsigned G_LEN = 2;

  // Even-branch taps for K=2, Q1.15, from h = [-1,0,9,16,9,0,-1]/32 with the x2 interpolation gain
  localparam logic signed [G_W-1:0] G [G_LEN] = '{-16'sd2048, 16'sd18432};

  function automatic int unsigned acc_width(int unsigned dw, int unsigned cw, int unsigned k);
    return dw + cw + $clog2(k) + 1;
  endfunction

  function automatic longint rnd_const(int unsigned cw);
    return longint'(1) <<< (cw - 2);
  endfunction

  typedef enum logic [1:0] {
    EMPTY,
    PH0,
    PH1
  } state_t;

endpackage

// File: rtl/hb_lane.sv
// One lane: delay line, symmetric pre-add MAC, round/saturate and bypass mux.
module hb_lane
  import hb_interp_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned K      = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              bypass,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] ev,
  output logic [DATA_W-1:0] od
);

  localparam int unsigned NT     = 2 * K;
  localparam int unsigned PRE_W  = DATA_W + 1;
  localparam int unsigned PROD_W = PRE_W + COEF_W;
  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, K);

  localparam logic signed [ACC_W-1:0] RNDV = ACC_W'(rnd_const(COEF_W));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((longint'(1) <<< (DATA_W - 1)) - longint'(1));
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(longint'(1) <<< (DATA_W - 1)));

  // The oldest tap of the 2K-deep line is never read, so only 2K-1 are stored.
  logic signed [DATA_W-1:0] d [NT-1];
  logic signed [DATA_W-1:0] t [NT];
  logic signed [PRE_W-1:0]  pre;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum_r;
  logic signed [ACC_W-1:0]  sh;
  logic signed [DATA_W-1:0] y;

  always_comb begin
    t[0] = x;
    for (int unsigned j = 1; j < NT; j++) begin
      t[j] = d[j-1];
    end
  end

  always_comb begin
    pre  = '0;
    prod = '0;
    acc  = '0;
    for (int unsigned j = 0; j < K; j++) begin
      pre  = PRE_W'(t[j]) + PRE_W'(t[NT-1-j]);
      prod = PROD_W'(pre) * PROD_W'(COEF_W'(G[j]));
      acc  = acc + ACC_W'(prod);
    end
    sum_r = acc + RNDV;
    sh    = sum_r >>> (COEF_W - 1);
    if (sh > MAXV) begin
      y = MAXV[DATA_W-1:0];
    end else if (sh < MINV) begin
      y = MINV[DATA_W-1:0];
    end else begin
      y = sh[DATA_W-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned j = 0; j < NT - 1; j++) begin
        d[j] <= '0;
      end
      ev <= '0;
      od <= '0;
    end else if (load) begin
      d[0] <= x;
      for (int unsigned j = 1; j < NT - 1; j++) begin
        d[j] <= d[j-1];
      end
      ev <= bypass ? x : y;
      od <= bypass ? x : t[K-1];
    end
  end

endmodule

// File: rtl/hb_interp2_mc.sv
// 2x halfband interpolator, N_CH lanes, valid/ready on a single clock; even phase then odd phase.
module hb_interp2_mc
  import hb_interp_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned N_CH   = 2,
  parameter int unsigned K      = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     io_in_valid,
  output logic                     io_in_ready,
  input  logic [N_CH*DATA_W-1:0]   io_in_data,
  input  logic                     io_bypass,
  output logic                     io_out_valid,
  input  logic                     io_out_ready,
  output logic [N_CH*DATA_W-1:0]   io_out_data
);

  state_t state, state_nxt;
  logic   accept, xfer;
  logic [N_CH*DATA_W-1:0] ev_bus, od_bus;

  assign io_in_ready  = !reset && ((state == EMPTY) || (state == PH1 && io_out_ready));
  assign io_out_valid = (state != EMPTY);
  assign accept       = io_in_valid && io_in_ready;
  assign xfer         = io_out_valid && io_out_ready;

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    hb_lane #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .K      (K)
    ) u_lane (
      .clock  (clock),
      .reset  (reset),
      .load   (accept),
      .bypass (io_bypass),
      .x      (io_in_data[c*DATA_W +: DATA_W]),
      .ev     (ev_bus[c*DATA_W +: DATA_W]),
      .od     (od_bus[c*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY:   if (accept) state_nxt = PH0;
      PH0:     if (xfer) state_nxt = PH1;
      PH1:     if (xfer) state_nxt = accept ? PH0 : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    case (state)
      PH0:     io_out_data = ev_bus;
      PH1:     io_out_data = od_bus;
      default: io_out_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

endmodule

// File: tb/tb_hb_interp2_mc.sv
// Scoreboard bench for hb_interp2_mc: zero-stuffed convolution reference model, random and directed stimulus.
module tb_hb_interp2_mc;

  localparam int DW = 16;
  localparam int NC = 2;

  logic clock = 1'b0;
  logic reset, in_valid, in_ready, bypass, out_valid, out_ready;
  logic [NC*DW-1:0] in_data, out_data;

  always #5 clock = ~clock;

  hb_interp2_mc #(
    .DATA_W (16),
    .COEF_W (16),
    .N_CH   (2),
    .K      (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_data   (in_data),
    .io_bypass    (bypass),
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_data  (out_data)
  );

  int tests = 0;
  int fails = 0;
  longint cyc = 0;
  always @(posedge clock) cyc++;

  // Prototype filter numerators (over 32); the model convolves the zero-stuffed input with 2*h.
  int hnum [7] = '{-1, 0, 9, 16, 9, 0, -1};
  int imp  [8] = '{-1024, 0, 9216, 16384, 9216, 0, -1024, 0};
  int hist [NC][8];

  logic [NC*DW-1:0] exp_q [$];
  int     log0 [$];
  int     log1 [$];
  longint xcyc [$];
  bit     rnd_ready = 0;
  bit     stall_prev = 0;
  logic [NC*DW-1:0] held;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic void shift_in(input int c, input int v);
    for (int i = 7; i > 0; i--) hist[c][i] = hist[c][i-1];
    hist[c][0] = v;
  endfunction

  function automatic int filt(input int c);
    longint s = 0;
    for (int m = 0; m < 7; m++) s += longint'(hnum[m]) * longint'(hist[c][m]);
    return sat16((s + 8) >>> 4);
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NC; c++)
      for (int i = 0; i < 8; i++) hist[c][i] = 0;
  endfunction

  function automatic logic [NC*DW-1:0] pk(input int a, input int b);
    logic [NC*DW-1:0] r;
    r[DW-1:0]    = a[DW-1:0];
    r[2*DW-1:DW] = b[DW-1:0];
    return r;
  endfunction

  task automatic model_accept(input logic [NC*DW-1:0] d, input logic byp);
    logic [NC*DW-1:0] ev, od;
    int x, e, o;
    ev = '0;
    od = '0;
    for (int c = 0; c < NC; c++) begin
      x = int'($signed(d[c*DW +: DW]));
      shift_in(c, x);
      e = filt(c);
      shift_in(c, 0);
      o = filt(c);
      if (byp) begin
        e = x;
        o = x;
      end
      ev[c*DW +: DW] = e[DW-1:0];
      od[c*DW +: DW] = o[DW-1:0];
    end
    exp_q.push_back(ev);
    exp_q.push_back(od);
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall behaviour.
  always @(negedge clock) begin
    if (reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", longint'(out_valid), 1);
        check("hold_data", longint'(out_data), longint'(held));
      end
      if (out_valid && !out_ready) begin
        check("stall_in_ready", longint'(in_ready), 0);
        held = out_data;
        stall_prev = 1;
      end else begin
        stall_prev = 0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("out_data", longint'(out_data), longint'(exp_q.pop_front()));
        end
        log0.push_back(int'($signed(out_data[DW-1:0])));
        log1.push_back(int'($signed(out_data[2*DW-1:DW])));
        xcyc.push_back(cyc);
      end
    end
  end

  always @(posedge clock) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  task automatic send(input logic [NC*DW-1:0] d, input logic byp);
    bit done = 0;
    in_data  = d;
    bypass   = byp;
    in_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clock);
      if (in_valid && in_ready) begin
        model_accept(d, byp);
        done = 1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok = 0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !out_valid) ok = 1;
      @(posedge clock);
      #1;
    end
    check("drain", longint'(ok), 1);
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    xcyc.delete();
  endtask

  task automatic impulse_and_check(input string name);
    clear_logs();
    send(pk(16384, 0), 0);
    repeat (3) send(pk(0, 0), 0);
    drain();
    check({name, "_count"}, log0.size(), 8);
    if (log0.size() == 8) begin
      for (int i = 0; i < 8; i++) check(name, log0[i], imp[i]);
    end
  endtask

  function automatic int rsamp();
    case ($urandom_range(0, 7))
      0:       return -32768;
      1:       return 32767;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    model_clear();
    in_valid  = 1'b0;
    in_data   = '0;
    bypass    = 1'b0;
    out_ready = 1'b1;
    reset     = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    check("reset_in_ready", longint'(in_ready), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_out_valid", longint'(out_valid), 0);
    check("reset_out_data", longint'(out_data), 0);
    check("idle_in_ready", longint'(in_ready), 1);
    @(posedge clock);
    #1;

    impulse_and_check("impulse");

    // DC on both lanes, back-to-back: outputs must be gap-free.
    clear_logs();
    repeat (8) send(pk(10000, 10000), 0);
    drain();
    check("dc_count", xcyc.size(), 16);
    if (xcyc.size() == 16) begin
      check("dc_gapfree_span", xcyc[15] - xcyc[0], 15);
      for (int i = 6; i < 16; i++) begin
        check("dc_lane0", log0[i], 10000);
        check("dc_lane1", log1[i], 10000);
      end
    end

    clear_logs();
    send(pk(-32768, 0), 0);
    send(pk(32767, 0), 0);
    send(pk(32767, 0), 0);
    send(pk(-32768, 0), 0);
    drain();
    check("sat_count", log0.size(), 8);
    if (log0.size() == 8) begin
      check("sat_even", log0[6], 32767);
      check("sat_odd", log0[7], 32767);
    end

    // Backpressure: stall PH0 for 3 cycles while a second vector waits.
    clear_logs();
    send(pk(111, 222), 0);
    out_ready = 1'b0;
    fork
      send(pk(333, 444), 0);
      begin
        repeat (3) @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", log0.size(), 4);

    // Fresh start, then bypass followed by an impulse on lane 1.
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    clear_logs();
    send(pk(1234, -5), 1);
    send(pk(0, 16384), 0);
    repeat (3) send(pk(0, 0), 0);
    drain();
    check("byp_count", log0.size(), 10);
    if (log0.size() == 10) begin
      check("byp_l0_ev", log0[0], 1234);
      check("byp_l1_ev", log1[0], -5);
      check("byp_l0_od", log0[1], 1234);
      check("byp_l1_od", log1[1], -5);
    end

    // Reset while presenting the odd phase.
    send(pk(16384, 0), 0);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("pre_reset_valid", longint'(out_valid), 1);
    #4;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    @(negedge clock);
    check("midreset_out_valid", longint'(out_valid), 0);
    check("midreset_out_data", longint'(out_data), 0);
    @(posedge clock);
    #1;
    impulse_and_check("impulse_after_reset");

    // Random traffic with random backpressure and bypass.
    rnd_ready = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clock);
        #1;
      end
      send(pk(rsamp(), rsamp()), ($urandom_range(0, 4) == 0));
    end
    rnd_ready = 0;
    @(posedge clock);
    #2;
    out_ready = 1'b1;
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
